// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core.
//   sw_state_t : FSM state encoding (IDLE/RUN/LAP/STOP)
//   bcd_time_t : packed MM:SS.CC time, six BCD digits, m1 most significant
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } sw_state_t;

  localparam int unsigned CS_MAX  = 99;
  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 99;
  localparam int unsigned TIME_W  = 24;

  typedef struct packed {
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
    logic [3:0] c1;
    logic [3:0] c0;
  } bcd_time_t;

endpackage

// File: rtl/sw_bcd_timer.sv
// BCD MM:SS.CC time register with same-cycle carry ripple and 99:59.99 wrap.
//   clk, rst_n : clock, async active-low reset
//   inc        : advance time by one centisecond
//   clr        : clear time to 00:00.00 (wins over inc)
//   t          : current time
module sw_bcd_timer
  import stopwatch_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      inc,
  input  logic      clr,
  output bcd_time_t t
);

  bcd_time_t t_q;
  bcd_time_t t_d;
  logic      cy_c;
  logic      cy_s;

  // True when a two-digit BCD field sits at its limit and must roll over.
  function automatic logic at_max(input logic [3:0] hi, input logic [3:0] lo,
                                  input int unsigned max);
    return (hi == 4'(max / 10)) && (lo == 4'(max % 10));
  endfunction

  // Next value of a two-digit BCD field, wrapping to 00 past its limit.
  function automatic logic [7:0] pair_next(input logic [3:0] hi, input logic [3:0] lo,
                                           input int unsigned max);
    logic [7:0] r;
    if (at_max(hi, lo, max))  r = 8'h00;
    else if (lo == 4'd9)      r = {hi + 4'd1, 4'd0};
    else                      r = {hi, lo + 4'd1};
    return r;
  endfunction

  // Increment with centisecond -> second -> minute carry chain.
  always_comb begin
    t_d  = t_q;
    cy_c = 1'b0;
    cy_s = 1'b0;
    if (clr) begin
      t_d = '0;
    end else if (inc) begin
      cy_c           = at_max(t_q.c1, t_q.c0, CS_MAX);
      {t_d.c1, t_d.c0} = pair_next(t_q.c1, t_q.c0, CS_MAX);
      if (cy_c) begin
        cy_s           = at_max(t_q.s1, t_q.s0, SEC_MAX);
        {t_d.s1, t_d.s0} = pair_next(t_q.s1, t_q.s0, SEC_MAX);
        if (cy_s) begin
          {t_d.m1, t_d.m0} = pair_next(t_q.m1, t_q.m0, MIN_MAX);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) t_q <= '0;
    else        t_q <= t_d;
  end

  assign t = t_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control core: start/stop/lap/reset FSM, centisecond prescaler,
// BCD time counter and lap snapshot feeding the six-digit display.
//   clk, rst_n     : clock, async active-low reset
//   btn_ss, btn_lr : one-cycle start/stop and lap/reset press pulses
//   disp_bcd       : {m1,m0,s1,s0,c1,c0}, lap snapshot while in LAP
//   state          : IDLE=0 RUN=1 LAP=2 STOP=3
//   running        : high in RUN or LAP
//   lap_active     : high in LAP
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_DIV = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_ss,
  input  logic              btn_lr,
  output logic [TIME_W-1:0] disp_bcd,
  output logic [1:0]        state,
  output logic              running,
  output logic              lap_active
);

  localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  sw_state_t     state_q;
  sw_state_t     state_d;
  logic          time_clr;
  logic          lap_load;
  logic          counting;
  logic          tick;
  logic [PW-1:0] pre_q;
  bcd_time_t     time_q;
  bcd_time_t     lap_q;

  // Counting decision uses the pre-edge state so a stopping press still
  // lets a coincident tick land.
  assign counting = (state_q == RUN) || (state_q == LAP);
  assign tick     = counting && (pre_q == PRE_LAST);

  // Next-state and control decode; btn_ss has priority over btn_lr.
  always_comb begin
    state_d  = state_q;
    time_clr = 1'b0;
    lap_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_ss)      state_d = RUN;
        else if (btn_lr) time_clr = 1'b1;
      end
      RUN: begin
        if (btn_ss) begin
          state_d = STOP;
        end else if (btn_lr) begin
          state_d  = LAP;
          lap_load = 1'b1;
        end
      end
      LAP: begin
        if (btn_ss)      state_d = STOP;
        else if (btn_lr) state_d = RUN;
      end
      STOP: begin
        if (btn_ss) begin
          state_d = RUN;
        end else if (btn_lr) begin
          state_d  = IDLE;
          time_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      running    <= 1'b0;
      lap_active <= 1'b0;
    end else begin
      state_q    <= state_d;
      running    <= (state_d == RUN) || (state_d == LAP);
      lap_active <= (state_d == LAP);
    end
  end

  assign state = state_q;

  // Centisecond prescaler; holds its phase while paused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pre_q <= '0;
    else if (time_clr) pre_q <= '0;
    else if (counting) pre_q <= tick ? '0 : pre_q + PW'(1);
  end

  // Lap snapshot captures the pre-increment time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        lap_q <= '0;
    else if (lap_load) lap_q <= time_q;
  end

  sw_bcd_timer u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (tick),
    .clr   (time_clr),
    .t     (time_q)
  );

  assign disp_bcd = lap_active ? lap_q : time_q;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control and timekeeping core of the FPGA stopwatch. Consumes the single-cycle press pulses produced by the per-button debouncers, runs a four-state start/stop/lap/reset state machine, and owns the centisecond prescaler, the BCD MM:SS.CC time counter and the lap snapshot register. It drives the six-digit display path directly.

## Interface

Parameters:
- CLK_DIV, default 500000: clk cycles per centisecond tick. The default suits 50 MHz. Legal values are ≥ 2.

Ports:
- clk, input, 1: system clock. All logic is rising-edge.
- rst_n, input, 1: asynchronous reset, active-low.
- btn_ss, input, 1: start/stop press, a one-cycle pulse from the debouncer.
- btn_lr, input, 1: lap/reset press, a one-cycle pulse from the debouncer.
- disp_bcd, output, 24: {m1,m0,s1,s0,c1,c0}. Each field is 4-bit BCD, with m1 as the most significant.
- state, output, 2: IDLE=0, RUN=1, LAP=2, STOP=3.
- running, output, 1: high in RUN or LAP.
- lap_active, output, 1: high in LAP.

## Operation

- Reset: while rst_n is low, the block asynchronously enters IDLE. The time register, lap register and prescaler are all cleared. disp_bcd=0, state=0, running=0, lap_active=0.
- If btn_ss and btn_lr are high in the same cycle, btn_ss wins and btn_lr is discarded.
- Transitions. Any state/input pair not listed below holds the current state.
  - IDLE: btn_ss goes to RUN. btn_lr stays in IDLE and re-clears the time register and prescaler.
  - RUN: btn_ss goes to STOP. btn_lr goes to LAP and loads the lap register with the time register's pre-edge value.
  - LAP: btn_ss goes to STOP and discards the lap display. btn_lr goes to RUN, releasing the display; no new snapshot is taken.
  - STOP: btn_ss goes to RUN and resumes with the prescaler value retained. btn_lr goes to IDLE and clears the time register and prescaler.
- Prescaler, counting 0..CLK_DIV-1:
  - Advances only while the current state is RUN or LAP; otherwise it holds.
  - tick = counting && (prescaler == CLK_DIV-1). On a tick the prescaler wraps to 0.
- Time counter, advanced by one on each tick:
  - Centiseconds run 00–99 and carry into seconds.
  - Seconds run 00–59 and carry into minutes.
  - Minutes run 00–99.
  - 99:59.99 + 1 wraps to 00:00.00 with no flag and no stop.
  - Each digit is always valid BCD. Carries ripple within the same cycle.
- Display: disp_bcd = lap_active ? lap register : time register. This is a 2:1 mux between two registers, with no additional register stage.

## Timing

- A button pulse sampled at edge N updates state at edge N. The new state is visible on the outputs after edge N.
- The counting decision at edge N uses the state before edge N:
  - A tick coinciding with a btn_ss press in RUN still increments the time, then the block stops.
  - A tick coinciding with a btn_ss press in STOP does not occur, because the prescaler was held. Counting starts on the next cycle.
- Lap snapshot coinciding with a tick: the lap register takes the pre-increment value, and the time register takes the incremented value.
- Tick-to-display latency is 0 cycles after the tick edge, when not in LAP.
- After resuming from STOP with prescaler value p, the first tick arrives CLK_DIV-1-p cycles after the transition edge plus one. Total counted cycles are preserved across pauses.
- Reset asserted mid-count takes effect immediately, asynchronously, with no completion of a pending tick. Release is synchronous to the next edge.

## Structure

- Package stopwatch_pkg holds:
  - the state enum (IDLE/RUN/LAP/STOP, 2-bit encoding as above)
  - the digit limit constants CS_MAX=99, SEC_MAX=59, MIN_MAX=99
  - the packed BCD time struct type (six 4-bit digits)
- Sub-module sw_bcd_timer:
  - Inputs: clk, rst_n, inc, clr. Output: the 24-bit BCD time.
  - Contains all carry and wrap logic.
- stopwatch_ctrl holds the FSM, the prescaler, the lap register and the display mux.

## Test plan

All scenarios use CLK_DIV=4.

- Reset/idle: assert rst_n=0 mid-run → state=0, disp_bcd=0, running=0 immediately; they stay 0 for 100 cycles after release with no presses.
- Count and stop: btn_ss, then 400 cycles, then btn_ss → disp_bcd=00:01.00 (0x000100), state=STOP. After a further 100 idle cycles the value is unchanged.
- Lap: in RUN at 00:00.50, press btn_lr → disp_bcd frozen at 0x000050 and lap_active=1. After 40 cycles, btn_lr → display shows 0x000060 and state=RUN.
- Resume/reset: STOP at 00:00.03 with prescaler=2, then btn_ss → next tick after 2 cycles. Then btn_ss, btn_lr → state=IDLE, disp_bcd=0.
- Wrap: preload or run to 99:59.99, one tick → 0x000000, state still RUN. Also cover the 00:59.99 → 01:00.00 and 09:59.99 → 10:00.00 carries.
- Simultaneous: btn_ss=btn_lr=1 in RUN → STOP with the lap register unchanged. Repeat on a tick edge → time incremented once.
